// File: rtl/timebase_pkg.sv
// Shared constants and digit helpers for the decade timebase generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package timebase_pkg;

    // Width of one BCD digit and the decade counting limits.
    localparam int TB_DIGIT_W    = 4;
    localparam int TB_DECADE_MAX = 9;
    localparam int TB_HALF       = 5;

    // Legal parameter ranges of timebase_gen.
    localparam int TB_CLK_MHZ_MIN = 2;
    localparam int TB_CLK_MHZ_MAX = 126;
    localparam int TB_STAGES_MIN  = 2;
    localparam int TB_STAGES_MAX  = 10;

    typedef logic [TB_DIGIT_W-1:0] digit_t;

    // Decade increment: 0..9 then back to 0.
    function automatic digit_t digit_inc(input digit_t d);
        if (d == digit_t'(TB_DECADE_MAX)) begin
            return '0;
        end
        return d + digit_t'(1);
    endfunction

endpackage

// File: rtl/decade_stage.sv
// One divide-by-ten stage: BCD counter advanced by the carry of the stage below.
// Latency: carry_out is combinational from carry_in; dcnt/sq update on the carrying edge.
// Backpressure: none; carry_in already carries the enable and clear gating.
module decade_stage
    import timebase_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clr,
    input  logic   carry_in,
    output digit_t dcnt,
    output logic   carry_out,
    output logic   sq
);

    digit_t dcnt_q, dcnt_d;
    logic   sq_q, sq_d;

    // Next count and square-wave level; sq tracks the new count so both move together.
    always_comb begin
        dcnt_d = dcnt_q;
        if (clr) begin
            dcnt_d = '0;
        end else if (carry_in) begin
            dcnt_d = digit_inc(dcnt_q);
        end
        sq_d = (dcnt_d >= digit_t'(TB_HALF));
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q <= '0;
            sq_q   <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            sq_q   <= sq_d;
        end
    end

    // Carry ripples combinationally so a full rollover ticks every stage in one cycle.
    assign carry_out = carry_in & (dcnt_q == digit_t'(TB_DECADE_MAX));
    assign dcnt      = dcnt_q;
    assign sq        = sq_q;

endmodule

// File: rtl/timebase_gen.sv
// Decade timebase: 1 MHz prescaler strobe plus cascaded /10 stages with ticks, squares and BCD.
// Latency: ticks are combinational from the counters; sq and bcd are registered, updated with the count.
// Backpressure: en low freezes everything and masks ticks; clr wins over en and masks ticks.
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int STAGES       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           clr,
    output logic [STAGES-1:0]              tick,
    output logic [STAGES-1:0]              sq,
    output logic [TB_DIGIT_W*(STAGES-1)-1:0] bcd
);

    localparam int            PW     = $clog2(CLK_FREQ_MHZ);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_FREQ_MHZ - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_FREQ_MHZ / 2);

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic              sq0_q, sq0_d;
    logic              tick0;
    logic [STAGES-1:0] carry;

    // Prescaler next state and the 1 MHz strobe; clr has priority and suppresses the strobe.
    always_comb begin
        tick0  = en & ~clr & (pcnt_q == P_LAST);
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick0 ? '0 : pcnt_q + PW'(1);
        end
        sq0_d = (pcnt_d >= P_HALF);
    end

    // Prescaler and stage-0 square-wave registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            sq0_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            sq0_q  <= sq0_d;
        end
    end

    assign carry[0] = tick0;
    assign sq[0]    = sq0_q;

    for (genvar k = 1; k < STAGES; k++) begin : g_stage
        decade_stage u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .carry_in  (carry[k-1]),
            .dcnt      (bcd[TB_DIGIT_W*(k-1) +: TB_DIGIT_W]),
            .carry_out (carry[k]),
            .sq        (sq[k])
        );
    end

    assign tick = carry;

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench: arithmetic reference model feeding a scoreboard queue, plus a default-parameter preload check.
// Latency: one expected entry per cycle, compared mid-cycle after the falling edge.
// Backpressure: n/a.
module tb_timebase_gen;

    localparam int     F   = 4;
    localparam int     S   = 3;
    localparam longint PER = F * 100;   // F * 10^(S-1): full cascade period

    logic       clk;
    logic       rst_n, en, clr;
    logic [S-1:0] tick, sq;
    logic [7:0] bcd;

    logic        rst_n_d, en_d, clr_d;
    logic [7:0]  tick_def, sq_def;
    logic [27:0] bcd_def;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [S-1:0] tick;
        logic [S-1:0] sq;
        logic [7:0]   bcd;
    } exp_t;

    exp_t   sb_q[$];
    longint n;   // enabled edges since last reset/clear, modulo PER

    timebase_gen #(.CLK_FREQ_MHZ(F), .STAGES(S)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .tick  (tick),
        .sq    (sq),
        .bcd   (bcd)
    );

    timebase_gen u_def (
        .clk   (clk),
        .rst_n (rst_n_d),
        .en    (en_d),
        .clr   (clr_d),
        .tick  (tick_def),
        .sq    (sq_def),
        .bcd   (bcd_def)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: outputs are pure functions of the enabled-edge count.
    function automatic logic [7:0] m_bcd(input longint cnt);
        logic [7:0] r = '0;
        longint unit = F;
        for (int j = 0; j < S - 1; j++) begin
            r[4*j +: 4] = 4'((cnt / unit) % 10);
            unit = unit * 10;
        end
        return r;
    endfunction

    function automatic logic [S-1:0] m_sq(input longint cnt);
        logic [S-1:0] r;
        logic [7:0]   d = m_bcd(cnt);
        r[0] = ((cnt % F) >= (F / 2));
        for (int k = 1; k < S; k++) begin
            r[k] = (d[4*(k-1) +: 4] >= 4'd5);
        end
        return r;
    endfunction

    function automatic logic [S-1:0] m_tick(input longint cnt, input logic e, input logic c);
        logic [S-1:0] r = '0;
        longint unit = F;
        for (int k = 0; k < S; k++) begin
            r[k] = e && !c && (((cnt + 1) % unit) == 0);
            unit = unit * 10;
        end
        return r;
    endfunction

    // One clock cycle of stimulus: drive, predict, advance the model.
    task automatic cycle(input logic e, input logic c);
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1;
        en    = e;
        clr   = c;
        x.tick = m_tick(n, e, c);
        x.sq   = m_sq(n);
        x.bcd  = m_bcd(n);
        sb_q.push_back(x);
        if (c) begin
            n = 0;
        end else if (e) begin
            n = (n + 1) % PER;
        end
    endtask

    // Reset held for a number of cycles; outputs must be zero before the next edge.
    task automatic do_reset(input int cycles);
        exp_t x;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            en    = 1'($urandom_range(0, 1));
            clr   = 1'b0;
            n     = 0;
            x.tick = '0;
            x.sq   = '0;
            x.bcd  = '0;
            sb_q.push_back(x);
        end
    endtask

    task automatic run_to(input logic [7:0] target, input bit need_tick_due);
        int guard = 0;
        while (!(m_bcd(n) == target && (!need_tick_due || (n % F) == F - 1)) && guard < 1000) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check("run_to_bound", 64'(guard < 1000), 64'd1);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set; compare it with the queued prediction.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("tick", 64'(tick), 64'(x.tick));
                check("sq",   64'(sq),   64'(x.sq));
                check("bcd",  64'(bcd),  64'(x.bcd));
            end
        end
    end

    initial begin
        int c;
        rst_n   = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        rst_n_d = 1'b0;
        en_d    = 1'b0;
        clr_d   = 1'b0;
        n       = 0;

        // Reset release, then more than a full cascade period with en held high.
        do_reset(3);
        for (int i = 0; i < 405; i++) cycle(1'b1, 1'b0);

        // Pause for 7 cycles at 0x37, then resume.
        run_to(8'h37, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

        // Clear at 0x95 exactly when a prescaler tick is due.
        run_to(8'h95, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

        // Reset mid-count at 0x52 for 3 cycles, then restart.
        run_to(8'h52, 1'b0);
        cycle(1'b1, 1'b0);
        do_reset(3);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);

        // Random enable/clear/reset traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
            end
        end
        cycle(1'b1, 1'b0);
        @(negedge clk);
        #3;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        // Default parameters: reset state, then tick[0] period of 50 cycles.
        @(negedge clk);
        #2;
        check("def_reset_tick", 64'(tick_def), 64'd0);
        check("def_reset_bcd",  64'(bcd_def),  64'd0);
        @(negedge clk);
        rst_n_d = 1'b1;
        en_d    = 1'b1;
        c = 0;
        do begin
            if (c > 0) @(negedge clk);
            #2;
            c++;
        end while (!tick_def[0] && c < 60);
        check("def_tick0_first", 64'(c), 64'd50);
        check("def_tick_upper_quiet", 64'(tick_def[7:1]), 64'd0);
        c = 0;
        do begin
            @(negedge clk);
            #2;
            c++;
        end while (!tick_def[0] && c < 60);
        check("def_tick0_period", 64'(c), 64'd50);

        // Preload every counter just short of a full rollover (saves 5e8 cycles).
        @(negedge clk);
        en_d = 1'b0;
        force u_def.pcnt_q = 6'd46;
        force u_def.g_stage[1].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[2].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[3].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[4].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[5].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[6].u_stage.dcnt_q = 4'd9;
        force u_def.g_stage[7].u_stage.dcnt_q = 4'd9;
        #1;
        release u_def.pcnt_q;
        release u_def.g_stage[1].u_stage.dcnt_q;
        release u_def.g_stage[2].u_stage.dcnt_q;
        release u_def.g_stage[3].u_stage.dcnt_q;
        release u_def.g_stage[4].u_stage.dcnt_q;
        release u_def.g_stage[5].u_stage.dcnt_q;
        release u_def.g_stage[6].u_stage.dcnt_q;
        release u_def.g_stage[7].u_stage.dcnt_q;
        c = 0;
        do begin
            @(negedge clk);
            en_d = 1'b1;
            #2;
            c++;
        end while (!tick_def[0] && c < 10);
        check("def_preload_wait", 64'(c), 64'd4);
        check("def_full_rollover_tick", 64'(tick_def), 64'hFF);
        check("def_preload_bcd", 64'(bcd_def), 64'h9999999);
        @(negedge clk);
        #2;
        check("def_after_wrap_bcd",  64'(bcd_def),  64'd0);
        check("def_after_wrap_tick", 64'(tick_def), 64'd0);
        check("def_after_wrap_sq",   64'(sq_def),   64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 50: input clock frequency in MHz; even integer, 2..126.
REQ-002 Parameter STAGES, default 8: number of decade stages; stage 0 = 1 MHz, stage k = 10^-k MHz (8 -> 1 MHz .. 0.1 Hz); range 2..10.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  count enable; low = freeze all counters.
REQ-006 clr  input  1  synchronous clear of all counters and outputs.
REQ-007 tick  output  STAGES  one-clk-cycle strobe per stage period; bit k = stage k.
REQ-008 sq  output  STAGES  registered 50%-duty square wave per stage, synchronous to clk.
REQ-009 bcd  output  4*(STAGES-1)  current decade count of stages 1..STAGES-1; digit j = bits [4j+3:4j] = stage j+1.

Function
REQ-010 Prescaler pcnt SHALL count 0..CLK_FREQ_MHZ-1 and wrap to 0 on each clk with en=1.
REQ-011 tick[0] SHALL be 1 for exactly the cycle in which pcnt == CLK_FREQ_MHZ-1 and en=1, else 0.
REQ-012 Stage k>=1 SHALL hold a 4-bit counter dcnt[k], incrementing 0..9 and wrapping to 0 only in cycles with tick[k-1]=1.
REQ-013 tick[k] (k>=1) SHALL equal tick[k-1] AND (dcnt[k]==9); all ticks of one cascade rollover assert in the same cycle (zero ripple latency, no derived clocks).
REQ-014 sq[0] SHALL be registered, equal to 1 while pcnt >= CLK_FREQ_MHZ/2, updated in the same cycle as pcnt.
REQ-015 sq[k] (k>=1) SHALL be registered, equal to 1 while dcnt[k] >= 5, updated in the same cycle as dcnt[k].
REQ-016 bcd SHALL reflect dcnt registers directly, never exceeding 9 per digit.
REQ-017 en=0: pcnt, dcnt, sq SHALL hold; all tick bits SHALL be 0; resume continues from held values.
REQ-018 clr=1: next edge SHALL set pcnt, all dcnt, sq to 0; tick SHALL be 0 during that cycle; clr has priority over en.
REQ-019 Wrap of the last stage SHALL assert tick[STAGES-1] and return all counters to 0 with no saturation or sticky flag.
REQ-020 Only clk SHALL clock any flop; no output SHALL be used as a clock internally.

Reset
REQ-021 rst_n=0 SHALL asynchronously force pcnt=0, all dcnt=0, sq=0, tick=0, bcd=0.
REQ-022 Deassertion SHALL be synchronised externally; first tick[0] SHALL occur CLK_FREQ_MHZ enabled cycles after the first enabled edge.
REQ-023 Reset mid-count SHALL discard all state; no partial period is preserved.

Structure
REQ-024 Shared package timebase_pkg SHALL hold TB_DIGIT_W=4, TB_DECADE_MAX=9, TB_HALF=5 and the legal-range limits of both parameters.
REQ-025 One sub-module decade_stage (ports clk, rst_n, clr, carry_in, dcnt, carry_out, sq) SHALL be instantiated STAGES-1 times via generate.
REQ-026 Prescaler and stage 0 SHALL live in timebase_gen itself.

Verification (CLK_FREQ_MHZ=4, STAGES=3 unless stated)
REQ-027 Reset release, en=1 -> tick[0] first high at cycle 4, then every 4 cycles; sq[0] low 2 / high 2 cycles.
REQ-028 Run 400 cycles -> tick[1] every 40 cycles, tick[2] once at cycle 400 coincident with tick[1] and tick[0]; bcd=0x00 after it.
REQ-029 en low for 7 cycles at bcd=0x37 -> bcd, sq hold, tick all 0; resume -> next tick[0] exactly as if paused time were removed.
REQ-030 clr with en=1 at bcd=0x95 -> next cycle bcd=0x00, sq=0, tick=0; clr and tick-due in same cycle -> no tick.
REQ-031 rst_n low for 3 cycles mid-count at bcd=0x52 -> outputs 0 asynchronously before next edge; count restarts from 0.
REQ-032 Defaults (50, 8) -> tick[0] period 50 cycles, tick[7] period 5e8 cycles (check via forced-counter preload shortcut).
